serial_adder: RTL



---
 rtl/serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that processes BPC bits per clock
// through a ripple of full-adder slices, finishing in WIDTH/BPC RUN cycles.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 2");
  end
  if (BPC < 1 || BPC > WIDTH) begin : g_bad_bpc
    $error("serial_adder: BPC must be between 1 and WIDTH");
  end
  if ((WIDTH % BPC) != 0) begin : g_bad_div
    $error("serial_adder: WIDTH must be divisible by BPC");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ps;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic [BPC-1:0]   w_sbits;
  logic [BPC:0]     w_cy;
  logic [WIDTH-1:0] w_ps_next;
  logic             w_last;

  // Ripple of BPC full-adder cells over the low bits of A and B, plus the
  // partial sum with the new result bits entering at the MSB end.
  always_comb begin
    w_sbits = '0;
    w_cy    = '0;
    w_cy[0] = r_c;
    for (int unsigned i = 0; i < BPC; i++) begin
      w_sbits[i]  = r_a[i] ^ r_b[i] ^ w_cy[i];
      w_cy[i + 1] = (r_a[i] & r_b[i]) | (w_cy[i] & (r_a[i] ^ r_b[i]));
    end
    // Shift-based merge keeps this legal when BPC == WIDTH (no zero-width slice).
    w_ps_next = (r_ps >> BPC) | (WIDTH'(w_sbits) << (WIDTH - BPC));
    w_last    = (r_cnt == CW'(N - 1));
  end

  // Control FSM with datapath registers and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ps    <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a   <= r_a >> BPC;
          r_b   <= r_b >> BPC;
          r_c   <= w_cy[BPC];
          r_ps  <= w_ps_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_ps_next;
            r_cout  <= w_cy[BPC];
            r_ovf   <= w_cy[BPC] ^ w_cy[BPC-1];
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub;
            r_ps    <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
